// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs 4 bytes MSB-first into a
// word, writes LOAD_WORDS words from BASE_ADDR, and stalls the core while loading.
module imem_loader #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned LOAD_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall
);

  localparam int unsigned CntW = $clog2(LOAD_WORDS + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Only the three newest bytes are kept; the fourth joins them on the way to wdata.
  logic [23:0]       shreg_q, shreg_d;
  logic [31:0]       wdata_q, wdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      shreg_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRecv;
          byte_idx_d = '0;
          word_cnt_d = '0;
          addr_d     = ADDR_W'(BASE_ADDR % DEPTH);
        end
      end
      StRecv: begin
        if (byte_valid) begin
          shreg_d    = {shreg_q[15:0], byte_in};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_d = {shreg_q, byte_in};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        word_cnt_d = word_cnt_q + CntW'(1);
        addr_d     = ADDR_W'((32'(addr_q) + 32'd1) % DEPTH);
        state_d    = (word_cnt_q == CntW'(LOAD_WORDS - 1)) ? StDone : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  // Every output is decoded from state or taken straight from a register.
  assign byte_ready = (state_q == StRecv);
  assign imem_we    = (state_q == StWrite);
  assign busy       = (state_q == StRecv) || (state_q == StWrite);
  assign done       = (state_q == StDone);
  assign cpu_stall  = busy;
  assign imem_waddr = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (base 0 / 8 words, base 30 / 4 words)
// share one stimulus stream and are each checked against a transaction-level model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;

  logic [1:0]  rdy, we, bsy, dn, stall;
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(32), .ADDR_W(5), .BASE_ADDR(0), .LOAD_WORDS(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy[0]), .imem_we(we[0]), .imem_waddr(waddr[0]), .imem_wdata(wdata[0]),
    .busy(bsy[0]), .done(dn[0]), .cpu_stall(stall[0])
  );

  imem_loader #(.DEPTH(32), .ADDR_W(5), .BASE_ADDR(30), .LOAD_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy[1]), .imem_we(we[1]), .imem_waddr(waddr[1]), .imem_wdata(wdata[1]),
    .busy(bsy[1]), .done(dn[1]), .cpu_stall(stall[1])
  );

  // Reference model: a load is a sequence of words; bytes accumulate arithmetically.
  int          base  [2] = '{0, 30};
  int          words [2] = '{8, 4};
  bit          loading [2];
  bit          finished [2];
  bit          wr [2];
  int          widx [2];
  int          nb [2];
  int          we_seen [2];
  logic [31:0] acc [2];
  logic [31:0] last [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      loading[d] = 0; finished[d] = 0; wr[d] = 0;
      widx[d] = 0; nb[d] = 0; we_seen[d] = 0;
      acc[d] = '0; last[d] = '0;
    end
  endtask

  task automatic model_step(input int d, input logic st, input logic bv, input logic [7:0] b);
    if (wr[d]) begin
      wr[d] = 0;
      widx[d]++;
      if (widx[d] == words[d]) begin
        loading[d]  = 0;
        finished[d] = 1;
        check($sformatf("d%0d_we_count", d), 32'(we_seen[d]), 32'(words[d]));
      end
    end else if (loading[d]) begin
      if (bv) begin
        acc[d] = acc[d] * 256 + 32'(b);
        nb[d]++;
        if (nb[d] == 4) begin
          last[d] = acc[d];
          nb[d]   = 0;
          wr[d]   = 1;
        end
      end
    end else if (st) begin
      loading[d]  = 1;
      finished[d] = 0;
      widx[d]     = 0;
      nb[d]       = 0;
      we_seen[d]  = 0;
    end
  endtask

  task automatic check_outputs(input int d);
    check($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(loading[d] && !wr[d]));
    check($sformatf("d%0d_we", d), 32'(we[d]), 32'(wr[d]));
    check($sformatf("d%0d_busy", d), 32'(bsy[d]), 32'(loading[d]));
    check($sformatf("d%0d_stall", d), 32'(stall[d]), 32'(loading[d]));
    check($sformatf("d%0d_done", d), 32'(dn[d]), 32'(finished[d]));
    check($sformatf("d%0d_wdata", d), wdata[d], last[d]);
    if (wr[d]) check($sformatf("d%0d_waddr", d), 32'(waddr[d]), 32'((base[d] + widx[d]) % 32));
    if (we[d] === 1'b1) we_seen[d]++;
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check 1 time unit later.
  task automatic tick(input logic st, input logic bv, input logic [7:0] b);
    start = st; byte_valid = bv; byte_in = b;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, st, bv, b);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_ready", d), 32'(rdy[d]), 32'd0);
      check($sformatf("d%0d_rst_we", d), 32'(we[d]), 32'd0);
      check($sformatf("d%0d_rst_busy", d), 32'(bsy[d]), 32'd0);
      check($sformatf("d%0d_rst_done", d), 32'(dn[d]), 32'd0);
      check($sformatf("d%0d_rst_stall", d), 32'(stall[d]), 32'd0);
      check($sformatf("d%0d_rst_waddr", d), 32'(waddr[d]), 32'd0);
      check($sformatf("d%0d_rst_wdata", d), wdata[d], 32'd0);
    end
    model_clear();
    #2;
    reset = 1'b0;
  endtask

  // mode 0: random valid density, 1: valid every cycle, 2: valid one cycle in three.
  task automatic run_until_done(input int mode, input int budget);
    int  cyc = 0;
    logic bv;
    while (!finished[0] && cyc < budget) begin
      case (mode)
        1:       bv = 1'b1;
        2:       bv = (cyc % 3 == 0);
        default: bv = ($urandom_range(0, 2) != 0);
      endcase
      tick($urandom_range(0, 9) == 0, bv, 8'($urandom));
      cyc++;
    end
    check("d0_load_done", 32'(finished[0]), 32'd1);
  endtask

  initial begin
    int cyc;
    model_clear();
    #2;
    do_reset();

    // Bytes offered while idle are ignored and never consumed.
    repeat (4) tick(1'b0, 1'b1, 8'($urandom));

    // First word from a clean start, bytes back to back.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h02);
    tick(1'b1, 1'b1, 8'h32);
    tick(1'b0, 1'b1, 8'h80);
    tick(1'b0, 1'b1, 8'h20);
    check("t1_we", 32'(we[0]), 32'd1);
    check("t1_waddr", 32'(waddr[0]), 32'd0);
    check("t1_wdata", wdata[0], 32'h02328020);
    check("t1_ready", 32'(rdy[0]), 32'd0);

    run_until_done(0, 2000);
    repeat (5) tick(1'b0, 1'b1, 8'($urandom));

    // Reset in the middle of word 3 after two of its bytes.
    tick(1'b1, 1'b0, 8'h00);
    cyc = 0;
    while (!(widx[0] == 3 && nb[0] == 2 && !wr[0]) && cyc < 500) begin
      tick(1'b0, (cyc % 3 == 0), 8'($urandom));
      cyc++;
    end
    check("t4_reached_word3", 32'(widx[0] * 4 + nb[0]), 32'd14);
    do_reset();
    repeat (3) tick(1'b0, 1'b1, 8'($urandom));

    // Reload from base with sparse valid, then dense valid.
    tick(1'b1, 1'b0, 8'h00);
    run_until_done(2, 3000);
    tick(1'b1, 1'b0, 8'h00);
    run_until_done(1, 1000);
    tick(1'b1, 1'b0, 8'h00);
    run_until_done(0, 2000);
    repeat (3) tick(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
